// File: rtl/fitness_eval_ctrl.sv
// rtl/fitness_eval_ctrl.sv - sequencing controller for the fitness_eval pipeline
//
// Loads the self-energy vector and interaction matrix from a config memory
// (optional, per start), streams POP_SIZE individuals from the population
// memory into fitness_eval, writes every returned total energy into the
// fitness memory and tracks the minimum-energy individual of the pass.
//
// Ports:
//   clk_i, rst_n                       clock, asynchronous active-low reset
//   start_i, load_cfg_i                pass request (sampled in IDLE only)
//   busy_o, done_o                     pass status, done is a 1-cycle pulse
//   cfg_rd_en_o/cfg_addr_o/cfg_rdata_i config memory read port (1-cycle latency)
//   pop_rd_en_o/pop_addr_o/pop_rdata_i population memory read port (1-cycle latency)
//   self_energy_o, wr_self_valid_o     energy table writes into fitness_eval
//   interact_energy_o, wr_interact_valid_o
//   in_valid_o, individual_vec_o, ind_idx_o   individual stream into fitness_eval
//   out_valid_i, total_energy_i, ind_wb_idx_i results from fitness_eval
//   fit_we_o, fit_addr_o, fit_wdata_o  fitness memory write port
//   best_energy_o, best_idx_o          minimum energy of the pass and its index
module fitness_eval_ctrl #(
  parameter int NUM_PARTICLE_TYPE = 3,
  parameter int DATA_WIDTH        = 4,
  parameter int INDIVIDUAL_LENGTH = 22,
  parameter int SELF_FIT_LENGTH   = 10,
  parameter int POP_SIZE          = 50,
  parameter int IDX_WIDTH         = 8,
  parameter int CFG_ADDR_WIDTH    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_n,
  input  logic                         start_i,
  input  logic                         load_cfg_i,
  output logic                         busy_o,
  output logic                         done_o,
  output logic                         cfg_rd_en_o,
  output logic [CFG_ADDR_WIDTH-1:0]    cfg_addr_o,
  input  logic [DATA_WIDTH-1:0]        cfg_rdata_i,
  output logic                         pop_rd_en_o,
  output logic [IDX_WIDTH-1:0]         pop_addr_o,
  input  logic [INDIVIDUAL_LENGTH-1:0] pop_rdata_i,
  output logic [DATA_WIDTH-1:0]        self_energy_o,
  output logic [DATA_WIDTH-1:0]        interact_energy_o,
  output logic                         wr_self_valid_o,
  output logic                         wr_interact_valid_o,
  output logic                         in_valid_o,
  output logic [INDIVIDUAL_LENGTH-1:0] individual_vec_o,
  output logic [IDX_WIDTH-1:0]         ind_idx_o,
  input  logic                         out_valid_i,
  input  logic [SELF_FIT_LENGTH-1:0]   total_energy_i,
  input  logic [IDX_WIDTH-1:0]         ind_wb_idx_i,
  output logic                         fit_we_o,
  output logic [IDX_WIDTH-1:0]         fit_addr_o,
  output logic [SELF_FIT_LENGTH-1:0]   fit_wdata_o,
  output logic [SELF_FIT_LENGTH-1:0]   best_energy_o,
  output logic [IDX_WIDTH-1:0]         best_idx_o
);

  localparam logic [CFG_ADDR_WIDTH-1:0] SE_LAST  = CFG_ADDR_WIDTH'(NUM_PARTICLE_TYPE - 1);
  localparam logic [CFG_ADDR_WIDTH-1:0] CFG_LAST =
    CFG_ADDR_WIDTH'(NUM_PARTICLE_TYPE + NUM_PARTICLE_TYPE * NUM_PARTICLE_TYPE - 1);
  localparam logic [IDX_WIDTH-1:0] POP_LAST  = IDX_WIDTH'(POP_SIZE - 1);
  localparam logic [IDX_WIDTH-1:0] POP_COUNT = IDX_WIDTH'(POP_SIZE);

  typedef enum logic [2:0] {
    S_IDLE, S_LD_SE, S_LD_IE, S_STREAM, S_DRAIN, S_DONE
  } state_e;

  state_e state_q, state_d;

  logic [CFG_ADDR_WIDTH-1:0]  cfg_cnt_q, cfg_cnt_d;
  logic [IDX_WIDTH-1:0]       pop_cnt_q, pop_cnt_d;
  logic [IDX_WIDTH-1:0]       res_cnt_q, res_cnt_d;
  logic                       wr_self_q, wr_self_d;
  logic                       wr_ie_q, wr_ie_d;
  logic                       in_valid_q, in_valid_d;
  logic [IDX_WIDTH-1:0]       ind_idx_q, ind_idx_d;
  logic                       fit_we_q, fit_we_d;
  logic [IDX_WIDTH-1:0]       fit_addr_q, fit_addr_d;
  logic [SELF_FIT_LENGTH-1:0] fit_wdata_q, fit_wdata_d;
  logic [SELF_FIT_LENGTH-1:0] best_energy_q, best_energy_d;
  logic [IDX_WIDTH-1:0]       best_idx_q, best_idx_d;

  logic start_acc;
  logic res_acc;

  assign start_acc = (state_q == S_IDLE) && start_i;
  // Results arriving outside STREAM/DRAIN belong to an aborted or finished pass.
  assign res_acc   = out_valid_i && ((state_q == S_STREAM) || (state_q == S_DRAIN));

  // State register and datapath flops
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cfg_cnt_q     <= '0;
      pop_cnt_q     <= '0;
      res_cnt_q     <= '0;
      wr_self_q     <= 1'b0;
      wr_ie_q       <= 1'b0;
      in_valid_q    <= 1'b0;
      ind_idx_q     <= '0;
      fit_we_q      <= 1'b0;
      fit_addr_q    <= '0;
      fit_wdata_q   <= '0;
      best_energy_q <= '1;
      best_idx_q    <= '0;
    end else begin
      state_q       <= state_d;
      cfg_cnt_q     <= cfg_cnt_d;
      pop_cnt_q     <= pop_cnt_d;
      res_cnt_q     <= res_cnt_d;
      wr_self_q     <= wr_self_d;
      wr_ie_q       <= wr_ie_d;
      in_valid_q    <= in_valid_d;
      ind_idx_q     <= ind_idx_d;
      fit_we_q      <= fit_we_d;
      fit_addr_q    <= fit_addr_d;
      fit_wdata_q   <= fit_wdata_d;
      best_energy_q <= best_energy_d;
      best_idx_q    <= best_idx_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_i) state_d = load_cfg_i ? S_LD_SE : S_STREAM;
      S_LD_SE:  if (cfg_cnt_q == SE_LAST) state_d = S_LD_IE;
      S_LD_IE:  if (cfg_cnt_q == CFG_LAST) state_d = S_STREAM;
      S_STREAM: if (pop_cnt_q == POP_LAST) state_d = S_DRAIN;
      S_DRAIN:  if (res_cnt_q == POP_COUNT) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Counters, pipeline-side registers and result tracking
  always_comb begin
    cfg_cnt_d     = cfg_cnt_q;
    pop_cnt_d     = pop_cnt_q;
    res_cnt_d     = res_cnt_q;
    fit_addr_d    = fit_addr_q;
    fit_wdata_d   = fit_wdata_q;
    best_energy_d = best_energy_q;
    best_idx_d    = best_idx_q;

    // One config address space: self energies first, matrix row-major after.
    if (state_q == S_IDLE) begin
      cfg_cnt_d = '0;
      pop_cnt_d = '0;
    end
    if ((state_q == S_LD_SE) || (state_q == S_LD_IE)) cfg_cnt_d = cfg_cnt_q + 1'b1;
    if (state_q == S_STREAM) pop_cnt_d = pop_cnt_q + 1'b1;

    // Strobes follow the read by one cycle, aligned with the memory's rdata.
    wr_self_d  = (state_q == S_LD_SE);
    wr_ie_d    = (state_q == S_LD_IE);
    in_valid_d = (state_q == S_STREAM);
    ind_idx_d  = (state_q == S_STREAM) ? pop_cnt_q : '0;

    fit_we_d = res_acc;
    if (res_acc) begin
      res_cnt_d   = res_cnt_q + 1'b1;
      fit_addr_d  = ind_wb_idx_i;
      fit_wdata_d = total_energy_i;
      // Strict compare keeps the earliest index on ties.
      if (total_energy_i < best_energy_q) begin
        best_energy_d = total_energy_i;
        best_idx_d    = ind_wb_idx_i;
      end
    end

    if (start_acc) begin
      res_cnt_d     = '0;
      best_energy_d = '1;
      best_idx_d    = '0;
    end
  end

  // Output logic
  always_comb begin
    busy_o              = (state_q != S_IDLE);
    done_o              = (state_q == S_DONE);
    cfg_rd_en_o         = (state_q == S_LD_SE) || (state_q == S_LD_IE);
    cfg_addr_o          = cfg_rd_en_o ? cfg_cnt_q : '0;
    pop_rd_en_o         = (state_q == S_STREAM);
    pop_addr_o          = pop_rd_en_o ? pop_cnt_q : '0;
    wr_self_valid_o     = wr_self_q;
    wr_interact_valid_o = wr_ie_q;
    self_energy_o       = wr_self_q ? cfg_rdata_i : '0;
    interact_energy_o   = wr_ie_q ? cfg_rdata_i : '0;
    in_valid_o          = in_valid_q;
    individual_vec_o    = in_valid_q ? pop_rdata_i : '0;
    ind_idx_o           = ind_idx_q;
    fit_we_o            = fit_we_q;
    fit_addr_o          = fit_addr_q;
    fit_wdata_o         = fit_wdata_q;
    best_energy_o       = best_energy_q;
    best_idx_o          = best_idx_q;
  end

endmodule

// File: tb/tb_fitness_eval_ctrl.sv
// tb/tb_fitness_eval_ctrl.sv - directed self-checking bench for fitness_eval_ctrl
module tb_fitness_eval_ctrl;

  localparam int POP = 50;

  logic        clk_i = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic        load_cfg_i = 1'b0;
  logic        busy_o, done_o;
  logic        cfg_rd_en_o;
  logic [3:0]  cfg_addr_o;
  logic [3:0]  cfg_rdata_i;
  logic        pop_rd_en_o;
  logic [7:0]  pop_addr_o;
  logic [21:0] pop_rdata_i;
  logic [3:0]  self_energy_o, interact_energy_o;
  logic        wr_self_valid_o, wr_interact_valid_o;
  logic        in_valid_o;
  logic [21:0] individual_vec_o;
  logic [7:0]  ind_idx_o;
  logic        out_valid_i;
  logic [9:0]  total_energy_i;
  logic [7:0]  ind_wb_idx_i;
  logic        fit_we_o;
  logic [7:0]  fit_addr_o;
  logic [9:0]  fit_wdata_o;
  logic [9:0]  best_energy_o;
  logic [7:0]  best_idx_o;

  int total = 0;
  int bad   = 0;

  fitness_eval_ctrl #(
    .NUM_PARTICLE_TYPE(3), .DATA_WIDTH(4), .INDIVIDUAL_LENGTH(22),
    .SELF_FIT_LENGTH(10), .POP_SIZE(POP), .IDX_WIDTH(8), .CFG_ADDR_WIDTH(4)
  ) dut (
    .clk_i(clk_i), .rst_n(rst_n), .start_i(start_i), .load_cfg_i(load_cfg_i),
    .busy_o(busy_o), .done_o(done_o),
    .cfg_rd_en_o(cfg_rd_en_o), .cfg_addr_o(cfg_addr_o), .cfg_rdata_i(cfg_rdata_i),
    .pop_rd_en_o(pop_rd_en_o), .pop_addr_o(pop_addr_o), .pop_rdata_i(pop_rdata_i),
    .self_energy_o(self_energy_o), .interact_energy_o(interact_energy_o),
    .wr_self_valid_o(wr_self_valid_o), .wr_interact_valid_o(wr_interact_valid_o),
    .in_valid_o(in_valid_o), .individual_vec_o(individual_vec_o), .ind_idx_o(ind_idx_o),
    .out_valid_i(out_valid_i), .total_energy_i(total_energy_i), .ind_wb_idx_i(ind_wb_idx_i),
    .fit_we_o(fit_we_o), .fit_addr_o(fit_addr_o), .fit_wdata_o(fit_wdata_o),
    .best_energy_o(best_energy_o), .best_idx_o(best_idx_o)
  );

  always #5 clk_i = ~clk_i;

  // Expected energy of individual k; minimum 7 appears twice (idx 12 and 30).
  function automatic int exp_e(input int k);
    if (k == 12 || k == 30) return 7;
    return 100 + 3 * k;
  endfunction

  // Config memory holds 1..12, population low bits chosen so that
  // low + (1+..+12 = 78) wraps to exp_e(k).
  logic [3:0]  cfg_mem [16];
  logic [21:0] pop_mem [256];

  initial begin
    for (int i = 0; i < 16; i++) cfg_mem[i] = 4'(i + 1);
    for (int k = 0; k < 256; k++) pop_mem[k] = {12'(k), 10'(exp_e(k) - 78)};
  end

  always @(posedge clk_i) begin
    if (cfg_rd_en_o) cfg_rdata_i <= cfg_mem[cfg_addr_o];
    if (pop_rd_en_o) pop_rdata_i <= pop_mem[pop_addr_o];
  end

  // Behavioural fitness_eval: sum of the 12 loaded table words plus the
  // individual's low bits, 4-cycle latency.
  logic [9:0] tsum = '0;
  int         wp = 0;
  logic       v1 = 0, v2 = 0, v3 = 0, v4 = 0;
  logic [9:0] e1, e2, e3, e4;
  logic [7:0] x1, x2, x3, x4;

  always @(posedge clk_i) begin
    if (wr_self_valid_o || wr_interact_valid_o) begin
      logic [3:0] val;
      val = wr_self_valid_o ? self_energy_o : interact_energy_o;
      if (wp == 0) tsum <= 10'(val);
      else         tsum <= tsum + 10'(val);
      wp <= (wp == 11) ? 0 : wp + 1;
    end
    v1 <= in_valid_o; e1 <= individual_vec_o[9:0] + tsum; x1 <= ind_idx_o;
    v2 <= v1; e2 <= e1; x2 <= x1;
    v3 <= v2; e3 <= e2; x3 <= x2;
    v4 <= v3; e4 <= e3; x4 <= x3;
  end

  assign out_valid_i    = v4;
  assign total_energy_i = e4;
  assign ind_wb_idx_i   = x4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_busy"}, 32'(busy_o), 0);
    chk({pfx, "_done"}, 32'(done_o), 0);
    chk({pfx, "_cfg_rd"}, 32'(cfg_rd_en_o), 0);
    chk({pfx, "_pop_rd"}, 32'(pop_rd_en_o), 0);
    chk({pfx, "_wr_self"}, 32'(wr_self_valid_o), 0);
    chk({pfx, "_wr_ie"}, 32'(wr_interact_valid_o), 0);
    chk({pfx, "_in_valid"}, 32'(in_valid_o), 0);
    chk({pfx, "_fit_we"}, 32'(fit_we_o), 0);
  endtask

  // One pass starting now; cycle 0 is the cycle start_i is sampled.
  task automatic run_pass(input bit load, input int rst_at, input int pulse_at);
    int base;
    int last;
    base = load ? 12 : 0;
    last = base + POP + 7;
    start_i = 1'b1; load_cfg_i = load;
    @(posedge clk_i); #1;
    start_i = 1'b0; load_cfg_i = 1'b0;
    for (int c = 1; c <= last + 1; c++) begin
      bit cr, ws, wi, pr, iv, fw;
      if (c == pulse_at) begin start_i = 1'b1; load_cfg_i = 1'b1; end
      if (c == rst_at) begin
        rst_n = 1'b0; #1;
        chk_quiet("rst");
        chk("rst_best_e", 32'(best_energy_o), 32'h3FF);
        chk("rst_best_i", 32'(best_idx_o), 0);
        repeat (2) @(posedge clk_i);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 15; k++) begin
          @(posedge clk_i); #1;
          chk_quiet("post_rst");
        end
        return;
      end
      cr = load && c >= 1 && c <= 12;
      ws = load && c >= 2 && c <= 4;
      wi = load && c >= 5 && c <= 13;
      pr = c >= base + 1 && c <= base + POP;
      iv = c >= base + 2 && c <= base + POP + 1;
      fw = c >= base + 7 && c <= base + POP + 6;
      chk("cfg_rd", 32'(cfg_rd_en_o), 32'(cr));
      if (cr) chk("cfg_addr", 32'(cfg_addr_o), 32'(c - 1));
      chk("wr_self", 32'(wr_self_valid_o), 32'(ws));
      if (ws) chk("self_data", 32'(self_energy_o), 32'(c - 1));
      chk("wr_ie", 32'(wr_interact_valid_o), 32'(wi));
      if (wi) chk("ie_data", 32'(interact_energy_o), 32'(c - 1));
      chk("pop_rd", 32'(pop_rd_en_o), 32'(pr));
      if (pr) chk("pop_addr", 32'(pop_addr_o), 32'(c - base - 1));
      chk("in_valid", 32'(in_valid_o), 32'(iv));
      if (iv) chk("ind_idx", 32'(ind_idx_o), 32'(c - base - 2));
      chk("fit_we", 32'(fit_we_o), 32'(fw));
      if (fw) begin
        chk("fit_addr", 32'(fit_addr_o), 32'(c - base - 7));
        chk("fit_wdata", 32'(fit_wdata_o), 32'(exp_e(c - base - 7)));
      end
      chk("done", 32'(done_o), 32'(c == last));
      chk("busy", 32'(busy_o), 32'(c <= last));
      @(posedge clk_i); #1;
      start_i = 1'b0; load_cfg_i = 1'b0;
    end
    chk("best_energy", 32'(best_energy_o), 7);
    chk("best_idx", 32'(best_idx_o), 12);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_best_e", 32'(best_energy_o), 32'h3FF);
    chk("reset_best_i", 32'(best_idx_o), 0);
    chk_quiet("reset");
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_i); #1;
      chk_quiet("idle");
      chk("idle_best_e", 32'(best_energy_o), 32'h3FF);
    end
    // Loaded pass: done at 69, busy low at 70.
    run_pass(1'b1, -1, -1);
    repeat (3) @(posedge clk_i);
    #1;
    // Reuse the loaded tables; a start pulse while busy must be ignored.
    run_pass(1'b0, -1, 10);
    repeat (3) @(posedge clk_i);
    #1;
    // Loaded pass aborted by reset at cycle 30; in-flight results must be dropped.
    run_pass(1'b1, 30, -1);
    // Fresh pass after the abort reuses the tables loaded before the reset.
    run_pass(1'b0, -1, 20);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fitness_eval_ctrl.md
# fitness_eval_ctrl

Sequencing controller for the `fitness_eval` pipeline. On `start_i` it optionally loads the self-energy vector and the interaction matrix from a configuration memory, then streams `POP_SIZE` individuals from the population memory. It collects the pipeline's results into a fitness memory and tracks the minimum-energy individual. It sits between the GA top-level scheduler and the `fitness_eval` instance, and is the only driver of that instance's inputs.

## Interface
Parameters:
- NUM_PARTICLE_TYPE, 3, particle types; config words = NPT + NPT² (12)
- DATA_WIDTH, 4, energy word width
- INDIVIDUAL_LENGTH, 22, individual vector width
- SELF_FIT_LENGTH, 10, total-energy width
- POP_SIZE, 50, individuals per evaluation pass
- IDX_WIDTH, 8, individual index / memory address width
- CFG_ADDR_WIDTH, 4, config memory address width

Ports:
- clk_i  in  1  clock; reset rst_n, asynchronous, active-low
- rst_n  in  1  asynchronous active-low reset
- start_i  in  1  start a pass; sampled only in IDLE
- load_cfg_i  in  1  sampled with start_i; 1 = reload energies before streaming
- busy_o  out  1  high from the cycle after an accepted start until done_o
- done_o  out  1  one-cycle pulse when the last result is written
- cfg_rd_en_o, cfg_addr_o  out  1, CFG_ADDR_WIDTH  config memory read; rdata valid next cycle
- cfg_rdata_i  in  DATA_WIDTH  config read data
- pop_rd_en_o, pop_addr_o  out  1, IDX_WIDTH  population memory read; rdata valid next cycle
- pop_rdata_i  in  INDIVIDUAL_LENGTH  individual read data
- self_energy_o, interact_energy_o  out  DATA_WIDTH  to fitness_eval
- wr_self_valid_o, wr_interact_valid_o  out  1  to fitness_eval write strobes
- in_valid_o  out  1  to fitness_eval
- individual_vec_o  out  INDIVIDUAL_LENGTH  to fitness_eval
- ind_idx_o  out  IDX_WIDTH  to fitness_eval
- out_valid_i  in  1  from fitness_eval
- total_energy_i  in  SELF_FIT_LENGTH  from fitness_eval
- ind_wb_idx_i  in  IDX_WIDTH  from fitness_eval
- fit_we_o, fit_addr_o, fit_wdata_o  out  1, IDX_WIDTH, SELF_FIT_LENGTH  fitness memory write
- best_energy_o, best_idx_o  out  SELF_FIT_LENGTH, IDX_WIDTH  minimum energy of the pass, and its index

## Operation
- States: IDLE, LD_SE, LD_IE, STREAM, DRAIN, DONE.
- IDLE, start_i=1:
  - load_cfg_i=1 → LD_SE.
  - load_cfg_i=0 → STREAM; the previously loaded energies are reused.
  - Clears the result counter, sets best_energy_o to all-ones, sets best_idx_o to 0.
- LD_SE: issues cfg_addr 0..NPT-1 on consecutive cycles, then → LD_IE.
- LD_IE: issues cfg_addr NPT..NPT+NPT²-1 in row-major order (row i, col j at NPT+i·NPT+j), then → STREAM.
- Config data path:
  - Config data is registered one cycle after each read.
  - Data is driven on self_energy_o / interact_energy_o with the matching strobe.
  - Strobes are strictly contiguous, with no gaps: 3 self strobes, then 9 interact strobes. fitness_eval's internal write pointer depends on this.
- STREAM:
  - Issues pop_addr 0..POP_SIZE-1, one per cycle.
  - The next cycle, in_valid_o=1 with individual_vec_o=pop_rdata_i and ind_idx_o=the issued address.
  - After the last address → DRAIN.
- Results:
  - Each out_valid_i in STREAM or DRAIN increments the result counter.
  - It registers fit_we_o=1, fit_addr_o=ind_wb_idx_i, fit_wdata_o=total_energy_i.
  - If total_energy_i < best_energy_o (strict), best_energy_o and best_idx_o are updated. On a tie the earlier index is kept.
  - out_valid_i in IDLE, LD_SE, LD_IE or DONE is ignored: no write, no count.
- DRAIN: waits until the result counter equals POP_SIZE, then → DONE.
- DONE: done_o=1 for one cycle, then → IDLE. best_* holds until the next accepted start.
- start_i while busy is ignored.

## Timing
- Reset: state IDLE; every output 0, except best_energy_o = all-ones.
- Start with load_cfg_i=1 sampled at cycle 0:
  - cfg reads at cycles 1–12.
  - wr_self_valid_o at cycles 2–4; wr_interact_valid_o at cycles 5–13.
  - pop reads at cycles 13..12+POP_SIZE; in_valid_o at cycles 14..13+POP_SIZE.
- Start with load_cfg_i=0: pop reads at cycles 1..POP_SIZE.
- fitness_eval latency is 4 cycles (in_valid to out_valid).
- fit_we_o follows out_valid_i by 1 cycle.
- done_o is asserted 1 cycle after the write of the last result. With load: cycle 13+POP_SIZE+4+2 = 69 for POP_SIZE=50.
- busy_o: from cycle 1 through the done_o cycle inclusive.
- Reset asserted mid-pass: all state, counters and best_* return to reset values immediately. No further strobes are issued.
- The fitness memory is assumed single-write-port. Only one write per cycle is possible by construction.

## Test plan
- Reset then idle → all outputs 0, best_energy_o=0x3FF, busy_o=0, no strobes for 20 cycles.
- start_i with load_cfg_i=1, cfg memory holds 1..12 → self strobes carry 1,2,3 at cycles 2–4; interact strobes carry 4..12 at cycles 5–13; no gaps.
- Full pass, POP_SIZE=50, population idx k ↦ known energies → 50 fit writes at addresses 0..49 with the model values; done_o at cycle 69; busy_o low at cycle 70.
- Energies with duplicate minimum 7 at idx 12 and 30 → best_energy_o=7, best_idx_o=12.
- start_i with load_cfg_i=0 after a loaded pass → no cfg reads; in_valid_o at cycles 2–51; results match the previous energy tables.
- rst_n low at cycle 30 of a pass, then a new start → no writes after reset; second pass completes with correct results; start_i pulsed while busy is ignored.
